// File: rtl/riscv_pkg.sv
// Shared RV32I constants used by the fetch front-end.
package riscv_pkg;
    localparam int              XLEN         = 32;
    localparam int              INSTR_BYTES  = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with flush; head is read straight from registered storage.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush wins over push and pop in the same cycle.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front-end: credit-limited in-order requests, prefetch buffer, redirect flush.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);
    localparam int            CW  = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     buf_count, inflight;
    logic              buf_empty, buf_full, pcq_empty, pcq_full;
    logic [2*XLEN-1:0] buf_head;
    logic [XLEN-1:0]   pcq_head;
    logic              req_fire, rsp_take, buf_push, buf_pop;

    // Buffered entries plus outstanding requests never exceed DEPTH, so the buffer cannot overflow.
    assign mem_req_valid = !rst && !redirect_valid && !pcq_full &&
                           (({1'b0, buf_count} + {1'b0, inflight}) < CAP);
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_take      = mem_rsp_valid && !pcq_empty;
    assign buf_push      = rsp_take && !redirect_valid && (drop_q == '0) && !buf_full;
    assign buf_pop       = instr_valid && instr_ready;

    assign instr_valid = !buf_empty;
    assign instr       = buf_empty ? '0 : buf_head[XLEN-1:0];
    assign instr_pc    = buf_empty ? '0 : buf_head[2*XLEN-1:XLEN];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still outstanding belongs to the old path, except a response landing now.
            fetch_pc_d = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            drop_d     = inflight - CW'(rsp_take);
        end else begin
            if (req_fire)                  fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (rsp_take && drop_q != '0)  drop_d     = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_prefetch_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (buf_push),
        .push_data_i ({pcq_head, mem_rsp_data}),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .count_o     (buf_count),
        .empty_o     (buf_empty),
        .full_o      (buf_full)
    );

    // Tracks the PC of every accepted request; its occupancy is the in-flight count.
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_inflight_pcq (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_take),
        .head_o      (pcq_head),
        .count_o     (inflight),
        .empty_o     (pcq_empty),
        .full_o      (pcq_full)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an epoch-based reference model and in-order memory.
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] mfifo[$];
    logic [31:0] m_pc;
    logic [31:0] next_pc;
    int          epoch;
    int          cyc;
    int          last_due;
    int          ready_pct, iready_pct, lat_min, lat_max;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr",  64'(mem_req_addr),  64'(RESET_PC));
        chk("rst_instr_vld", 64'(instr_valid),   64'd0);
        chk("rst_instr",     64'(instr),         64'd0);
        chk("rst_instr_pc",  64'(instr_pc),      64'd0);
    endtask

    task automatic model_reset();
        pend.delete();
        mfifo.delete();
        m_pc     = RESET_PC;
        next_pc  = RESET_PC;
        epoch++;
        last_due = -1;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model, cross the edge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit    rsp, exp_valid, acc, pop;
        pend_t r;
        int    lat;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = ($urandom_range(99) < ready_pct);
        instr_ready    = ($urandom_range(99) < iready_pct);
        rsp            = (pend.size() > 0) && (pend[0].due <= cyc);
        if (rsp) assert (pend.size() > 0);
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? memf(pend[0].addr) : $urandom;
        #1;
        exp_valid = !redir && ((mfifo.size() + pend.size()) < DEPTH);
        chk("req_valid",   64'(mem_req_valid), 64'(exp_valid));
        chk("req_addr",    64'(mem_req_addr),  64'(m_pc));
        chk("instr_valid", 64'(instr_valid),   64'(mfifo.size() > 0));
        chk("instr_pc",    64'(instr_pc),      64'(mfifo.size() > 0 ? mfifo[0] : 32'h0));
        chk("instr",       64'(instr),         64'(mfifo.size() > 0 ? memf(mfifo[0]) : 32'h0));
        acc = exp_valid && mem_req_ready;
        pop = (mfifo.size() > 0) && instr_ready;
        if (rsp) r = pend.pop_front();
        if (redir) begin
            mfifo.delete();
            m_pc    = rpc & ~32'h3;
            next_pc = m_pc;
            epoch++;
        end else begin
            if (pop) begin
                chk("pc_seq", 64'(instr_pc), 64'(next_pc));
                next_pc += 32'd4;
                void'(mfifo.pop_front());
            end
            if (rsp && r.epoch == epoch) mfifo.push_back(r.addr);
            if (acc) begin
                lat = $urandom_range(lat_max, lat_min);
                r.addr  = m_pc;
                r.epoch = epoch;
                r.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = r.due;
                pend.push_back(r);
                m_pc += 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic knobs(input int rp, input int ip, input int lmin, input int lmax);
        ready_pct  = rp;
        iready_pct = ip;
        lat_min    = lmin;
        lat_max    = lmax;
    endtask

    initial begin
        bit reached;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        instr_ready    = 1'b0;
        cyc            = 0;
        epoch          = 0;
        model_reset();
        #3;
        chk_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with single-cycle memory.
        knobs(100, 100, 1, 1);
        repeat (20) step(1'b0, '0);

        // Decode stalled: credit fills, then drains in order.
        knobs(100, 0, 1, 1);
        repeat (10) step(1'b0, '0);
        knobs(100, 100, 1, 1);
        repeat (12) step(1'b0, '0);

        // Redirect to an unaligned target with two requests outstanding.
        do_reset();
        knobs(100, 100, 3, 3);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (pend.size() == 2) reached = 1'b1;
            else step(1'b0, '0);
        end
        chk("two_inflight_reached", 64'(reached), 64'd1);
        step(1'b1, 32'h0000_0103);
        chk("redir_addr", 64'(mem_req_addr), 64'h100);
        knobs(100, 100, 1, 1);
        repeat (15) step(1'b0, '0);

        // Redirect while a response arrives and decode is consuming.
        knobs(100, 100, 1, 1);
        repeat (6) step(1'b0, '0);
        step(1'b1, 32'h0000_2000);
        repeat (10) step(1'b0, '0);

        // Random traffic with occasional redirects.
        knobs(60, 70, 1, 3);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) step(1'b1, $urandom);
            else step(1'b0, '0);
        end

        // Asynchronous reset with three instructions buffered.
        knobs(100, 0, 1, 1);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            if (mfifo.size() == 3) reached = 1'b1;
            else step(1'b0, '0);
        end
        chk("three_buffered_reached", 64'(reached), 64'd1);
        do_reset();
        knobs(100, 100, 1, 2);
        repeat (20) step(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
